// File: rtl/rx_pkt_dequeue.sv
`default_nettype none
// ============================================================================
// Module   : rx_pkt_dequeue
// Desc     : Read-side packet framer for the 10G MAC receive path. Drains
//            status+data words from the receive data FIFO (first-word
//            fall-through) and presents them as registered packet words with
//            SOP/EOP/ERR/MOD flags. Advertises a waiting frame from the
//            packet-count FIFO and resynchronises on broken framing by
//            discarding words up to the next SOP, counting each discard.
// Revision : 1.0 - initial release
// ============================================================================
module rx_pkt_dequeue (
  input  logic        clk_156m25,
  input  logic        reset_156m25_n,
  input  logic [63:0] rxdfifo_rdata,
  input  logic [7:0]  rxdfifo_rstatus,
  input  logic        rxdfifo_rempty,
  output logic        rxdfifo_ren,
  input  logic        rxsfifo_rempty,
  output logic        rxsfifo_ren,
  input  logic        pkt_rx_ren,
  output logic        pkt_rx_avail,
  output logic        pkt_rx_val,
  output logic [63:0] pkt_rx_data,
  output logic        pkt_rx_sop,
  output logic        pkt_rx_eop,
  output logic        pkt_rx_err,
  output logic [2:0]  pkt_rx_mod,
  output logic [15:0] rx_drop_cnt
);

  // FSM encoding
  localparam logic [1:0] c_ST_IDLE = 2'd0;  // no frame open
  localparam logic [1:0] c_ST_READ = 2'd1;  // frame open, delivering words
  localparam logic [1:0] c_ST_DROP = 2'd2;  // discarding until the next SOP

  // Status byte field positions
  localparam int c_SOP_BIT = 7;
  localparam int c_EOP_BIT = 6;
  localparam int c_ERR_BIT = 5;

  // Abort word presented when a frame is cut short by a new SOP
  localparam logic [2:0]  c_ABORT_MOD  = 3'd1;
  localparam logic [15:0] c_CNT_MAX    = 16'hFFFF;

  logic [1:0] r_state;
  logic [1:0] w_state_nxt;

  logic       w_head_vld;
  logic       w_head_sop;
  logic       w_head_eop;
  logic       w_head_err;
  logic [2:0] w_head_mod;

  logic       w_user_pop;
  logic       w_drop_pop;
  logic       w_abort;
  logic       w_avail_raw;
  logic       w_pop;

  // Reserved status bits [4:3] carry nothing for this block
  logic       w_unused_status;
  assign w_unused_status = ^rxdfifo_rstatus[4:3];

  // Decode the fall-through head word of the data FIFO
  always_comb begin
    w_head_vld = !rxdfifo_rempty;
    w_head_sop = rxdfifo_rstatus[c_SOP_BIT];
    w_head_eop = rxdfifo_rstatus[c_EOP_BIT];
    w_head_err = rxdfifo_rstatus[c_ERR_BIT];
    w_head_mod = rxdfifo_rstatus[2:0];
  end

  // Next-state and pop decisions from the current state and the head word
  always_comb begin
    w_state_nxt = r_state;
    w_user_pop  = 1'b0;
    w_drop_pop  = 1'b0;
    w_abort     = 1'b0;
    w_avail_raw = 1'b0;
    case (r_state)
      c_ST_IDLE: begin
        w_avail_raw = !rxsfifo_rempty;
        if (w_head_vld && !w_head_sop) begin
          // Head is not a frame start: framing is lost, resync first
          w_state_nxt = c_ST_DROP;
        end else if (w_head_vld && pkt_rx_ren && !rxsfifo_rempty) begin
          w_user_pop = 1'b1;
          // A single-word frame opens and closes in the same pop
          if (!w_head_eop) begin
            w_state_nxt = c_ST_READ;
          end
        end
      end
      c_ST_READ: begin
        if (w_head_vld) begin
          if (w_head_sop) begin
            // Current frame never got its EOP; close it with an abort word
            // and leave the new SOP in the FIFO for the next request.
            w_abort     = 1'b1;
            w_state_nxt = c_ST_IDLE;
          end else if (pkt_rx_ren) begin
            w_user_pop = 1'b1;
            if (w_head_eop) begin
              w_state_nxt = c_ST_IDLE;
            end
          end
        end
      end
      c_ST_DROP: begin
        if (w_head_vld && !w_head_sop) begin
          w_drop_pop = 1'b1;
        end else begin
          w_state_nxt = c_ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = c_ST_IDLE;
      end
    endcase
  end

  // FIFO pops are held off while reset is asserted; every EOP word leaving
  // the data FIFO (delivered or dropped) retires one packet-count entry.
  assign w_pop        = w_user_pop | w_drop_pop;
  assign rxdfifo_ren  = reset_156m25_n & w_pop;
  assign rxsfifo_ren  = reset_156m25_n & w_pop & w_head_eop;
  assign pkt_rx_avail = reset_156m25_n & w_avail_raw;

  // State register
  always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
    if (!reset_156m25_n) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Output word register: load on a user pop or abort, otherwise hold fields
  always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
    if (!reset_156m25_n) begin
      pkt_rx_val  <= 1'b0;
      pkt_rx_data <= 64'd0;
      pkt_rx_sop  <= 1'b0;
      pkt_rx_eop  <= 1'b0;
      pkt_rx_err  <= 1'b0;
      pkt_rx_mod  <= 3'd0;
    end else begin
      pkt_rx_val <= w_user_pop | w_abort;
      if (w_user_pop) begin
        pkt_rx_data <= rxdfifo_rdata;
        pkt_rx_sop  <= w_head_sop;
        pkt_rx_eop  <= w_head_eop;
        pkt_rx_err  <= w_head_err;
        pkt_rx_mod  <= w_head_mod;
      end else if (w_abort) begin
        pkt_rx_data <= 64'd0;
        pkt_rx_sop  <= 1'b0;
        pkt_rx_eop  <= 1'b1;
        pkt_rx_err  <= 1'b1;
        pkt_rx_mod  <= c_ABORT_MOD;
      end
    end
  end

  // Saturating count of words discarded during resync
  always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
    if (!reset_156m25_n) begin
      rx_drop_cnt <= 16'd0;
    end else if (w_drop_pop && (rx_drop_cnt != c_CNT_MAX)) begin
      rx_drop_cnt <= rx_drop_cnt + 16'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rx_pkt_dequeue.sv
`default_nettype none
// ============================================================================
// Module   : tb_rx_pkt_dequeue
// Desc     : Self-checking bench for rx_pkt_dequeue. Models the data FIFO and
//            packet-count FIFO as queues, predicts every output each cycle
//            from the framing rules, and pins a few results to literals.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rx_pkt_dequeue;

  localparam int M_IDLE = 0;
  localparam int M_OPEN = 1;
  localparam int M_DROP = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] rdata = 64'd0;
  logic [7:0]  rstatus = 8'd0;
  logic        rempty = 1'b1;
  logic        sempty = 1'b1;
  logic        ren_u = 1'b0;

  logic        rxdfifo_ren;
  logic        rxsfifo_ren;
  logic        pkt_rx_avail;
  logic        pkt_rx_val;
  logic [63:0] pkt_rx_data;
  logic        pkt_rx_sop;
  logic        pkt_rx_eop;
  logic        pkt_rx_err;
  logic [2:0]  pkt_rx_mod;
  logic [15:0] rx_drop_cnt;

  rx_pkt_dequeue dut (
    .clk_156m25      (clk),
    .reset_156m25_n  (rst_n),
    .rxdfifo_rdata   (rdata),
    .rxdfifo_rstatus (rstatus),
    .rxdfifo_rempty  (rempty),
    .rxdfifo_ren     (rxdfifo_ren),
    .rxsfifo_rempty  (sempty),
    .rxsfifo_ren     (rxsfifo_ren),
    .pkt_rx_ren      (ren_u),
    .pkt_rx_avail    (pkt_rx_avail),
    .pkt_rx_val      (pkt_rx_val),
    .pkt_rx_data     (pkt_rx_data),
    .pkt_rx_sop      (pkt_rx_sop),
    .pkt_rx_eop      (pkt_rx_eop),
    .pkt_rx_err      (pkt_rx_err),
    .pkt_rx_mod      (pkt_rx_mod),
    .rx_drop_cnt     (rx_drop_cnt)
  );

  initial forever #5 clk = ~clk;

  // FIFO models: entries are {status, data}
  logic [71:0] fifo_q[$];
  logic [71:0] src_q[$];
  logic [71:0] out_log[$];
  int          scount = 0;
  logic        gap = 1'b0;
  logic        pend_d = 1'b0;
  logic        pend_s = 1'b0;
  int          dut_spops = 0;

  // Behavioural expectations
  int          m_mode = M_IDLE;
  int          m_drops = 0;
  logic        e_val = 1'b0;
  logic [63:0] e_data = 64'd0;
  logic        e_sop = 1'b0;
  logic        e_eop = 1'b0;
  logic        e_err = 1'b0;
  logic [2:0]  e_mod = 3'd0;
  logic [15:0] e_cnt = 16'd0;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_entry(input string nm, input int idx, input logic [7:0] st, input logic [63:0] d);
    if (idx < out_log.size()) begin
      chk(nm, out_log[idx], {st, d});
    end else begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: got no word expected %0h", nm, {st, d});
    end
  endtask

  function automatic logic [71:0] mkw(input logic [7:0] st, input logic [63:0] d);
    return {st, d};
  endfunction

  task automatic drive_head();
    if (fifo_q.size() > 0 && !gap) begin
      rempty = 1'b0;
      {rstatus, rdata} = fifo_q[0];
    end else begin
      rempty  = 1'b1;
      rstatus = 8'($urandom);
      rdata   = {$urandom(), $urandom()};
    end
    sempty = (scount == 0);
  endtask

  task automatic push(input logic [71:0] w);
    fifo_q.push_back(w);
    if (w[70]) scount++;
    drive_head();
  endtask

  // Per-cycle comparison against the framing rules, evaluated mid-cycle
  task automatic cycle_check();
    logic        vis, hs, he, dpop, spop, upop, abort, m_avail;
    logic [71:0] h;
    int          nmode;
    if (!rst_n) begin
      chk("rst_val", pkt_rx_val, 0);
      chk("rst_data", pkt_rx_data, 0);
      chk("rst_flags", {pkt_rx_sop, pkt_rx_eop, pkt_rx_err, pkt_rx_mod}, 0);
      chk("rst_cnt", rx_drop_cnt, 0);
      chk("rst_avail", pkt_rx_avail, 0);
      chk("rst_dren", rxdfifo_ren, 0);
      chk("rst_sren", rxsfifo_ren, 0);
      m_mode = M_IDLE; m_drops = 0;
      e_val = 0; e_data = 0; e_sop = 0; e_eop = 0; e_err = 0; e_mod = 0; e_cnt = 0;
      pend_d = 0; pend_s = 0;
    end else begin
      chk("val", pkt_rx_val, e_val);
      chk("data", pkt_rx_data, e_data);
      chk("flags", {pkt_rx_sop, pkt_rx_eop, pkt_rx_err, pkt_rx_mod}, {e_sop, e_eop, e_err, e_mod});
      chk("drop_cnt", rx_drop_cnt, e_cnt);
      if (pkt_rx_val) out_log.push_back({pkt_rx_sop, pkt_rx_eop, pkt_rx_err, 2'b00, pkt_rx_mod, pkt_rx_data});
      if (rxsfifo_ren) dut_spops++;

      vis = !gap && (fifo_q.size() > 0);
      h = '0;
      if (vis) h = fifo_q[0];
      hs = h[71]; he = h[70];
      m_avail = (m_mode == M_IDLE) && (scount > 0);
      dpop = 0; upop = 0; abort = 0; nmode = m_mode;
      if (m_mode == M_IDLE) begin
        if (vis && !hs) nmode = M_DROP;
        else if (vis && ren_u && m_avail) begin
          upop = 1; dpop = 1;
          nmode = he ? M_IDLE : M_OPEN;
        end
      end else if (m_mode == M_OPEN) begin
        if (vis && hs) begin abort = 1; nmode = M_IDLE; end
        else if (vis && ren_u) begin
          upop = 1; dpop = 1;
          if (he) nmode = M_IDLE;
        end
      end else begin
        if (vis && !hs) begin dpop = 1; m_drops++; end
        else nmode = M_IDLE;
      end
      spop = dpop && he;

      chk("avail", pkt_rx_avail, m_avail);
      chk("dfifo_ren", rxdfifo_ren, dpop);
      chk("sfifo_ren", rxsfifo_ren, spop);

      e_val = upop || abort;
      if (upop) begin
        e_data = h[63:0]; e_sop = hs; e_eop = he; e_err = h[69]; e_mod = h[66:64];
      end else if (abort) begin
        e_data = 0; e_sop = 0; e_eop = 1; e_err = 1; e_mod = 3'd1;
      end
      e_cnt = (m_drops > 65535) ? 16'hFFFF : 16'(m_drops);
      m_mode = nmode;
      pend_d = dpop;
      pend_s = spop;
    end
  endtask

  // One clock: check mid-cycle, then commit pops just after the edge
  task automatic step();
    @(negedge clk);
    cycle_check();
    @(posedge clk);
    #1;
    if (pend_d && fifo_q.size() > 0) void'(fifo_q.pop_front());
    if (pend_s && scount > 0) scount--;
    drive_head();
  endtask

  task automatic gen_stream(input int nframes);
    int r, len;
    logic [7:0] st;
    for (int f = 0; f < nframes; f++) begin
      r = $urandom_range(0, 99);
      if (r < 12) begin
        len = $urandom_range(1, 2);
        for (int i = 0; i < len; i++) begin
          st = {1'b0, 1'($urandom), 1'($urandom), 2'b00, 3'($urandom)};
          src_q.push_back({st, $urandom(), $urandom()});
        end
      end else if (r < 22) begin
        len = $urandom_range(1, 3);
        for (int i = 0; i < len; i++) begin
          st = {(i == 0), 1'b0, 1'($urandom), 2'b00, 3'($urandom)};
          src_q.push_back({st, $urandom(), $urandom()});
        end
      end else begin
        len = $urandom_range(1, 6);
        for (int i = 0; i < len; i++) begin
          st = {(i == 0), (i == len - 1), 1'($urandom), 2'b00, 3'($urandom)};
          src_q.push_back({st, $urandom(), $urandom()});
        end
      end
    end
    src_q.push_back(mkw(8'h80, 64'hF1));
    src_q.push_back(mkw(8'h45, 64'hF2));
  endtask

  initial begin
    int sp0, cyc;
    drive_head();
    repeat (3) step();
    rst_n = 1'b1;
    repeat (2) step();
    chk("init_drop_cnt", rx_drop_cnt, 16'd0);

    // 3-word frame
    out_log.delete(); sp0 = dut_spops;
    push(mkw(8'h80, 64'hA1)); push(mkw(8'h00, 64'hA2)); push(mkw(8'h43, 64'hA3));
    ren_u = 1'b1;
    repeat (6) step();
    ren_u = 1'b0;
    step();
    chk("t1_words", out_log.size(), 3);
    chk_entry("t1_w0", 0, 8'h80, 64'hA1);
    chk_entry("t1_w1", 1, 8'h00, 64'hA2);
    chk_entry("t1_w2", 2, 8'h43, 64'hA3);
    chk("t1_spop", dut_spops - sp0, 1);

    // single-word frame
    out_log.delete(); sp0 = dut_spops;
    push(mkw(8'hC0, 64'hB1));
    ren_u = 1'b1;
    repeat (3) step();
    ren_u = 1'b0;
    step();
    chk("t2_words", out_log.size(), 1);
    chk_entry("t2_w0", 0, 8'hC0, 64'hB1);
    chk("t2_spop", dut_spops - sp0, 1);

    // stray words ahead of a frame
    out_log.delete(); sp0 = dut_spops;
    push(mkw(8'h00, 64'hC1)); push(mkw(8'h40, 64'hC2));
    push(mkw(8'h80, 64'hC3)); push(mkw(8'h41, 64'hC4));
    repeat (5) step();
    chk("t3_drop_cnt", rx_drop_cnt, 16'd2);
    chk("t3_drop_spop", dut_spops - sp0, 1);
    ren_u = 1'b1;
    repeat (4) step();
    ren_u = 1'b0;
    step();
    chk("t3_words", out_log.size(), 2);
    chk_entry("t3_w0", 0, 8'h80, 64'hC3);
    chk_entry("t3_w1", 1, 8'h41, 64'hC4);

    // truncated frame followed by a new SOP
    out_log.delete(); sp0 = dut_spops;
    push(mkw(8'h80, 64'hD1)); push(mkw(8'h00, 64'hD2));
    push(mkw(8'h80, 64'hD3)); push(mkw(8'h00, 64'hD4)); push(mkw(8'h41, 64'hD5));
    ren_u = 1'b1;
    repeat (9) step();
    ren_u = 1'b0;
    step();
    chk("t4_words", out_log.size(), 6);
    chk_entry("t4_w1", 1, 8'h00, 64'hD2);
    chk_entry("t4_abort", 2, 8'h61, 64'h0);
    chk_entry("t4_new_sop", 3, 8'h80, 64'hD3);
    chk_entry("t4_new_eop", 5, 8'h41, 64'hD5);
    chk("t4_spop", dut_spops - sp0, 1);

    // ren toggling plus a 2-cycle empty FIFO mid-frame
    out_log.delete();
    push(mkw(8'h80, 64'hE1)); push(mkw(8'h00, 64'hE2));
    push(mkw(8'h00, 64'hE3)); push(mkw(8'h43, 64'hE4));
    ren_u = 1'b1; step();
    ren_u = 1'b0; step();
    ren_u = 1'b1; step();
    gap = 1'b1; drive_head();
    repeat (2) step();
    gap = 1'b0; drive_head();
    repeat (4) step();
    ren_u = 1'b0;
    step();
    chk("t5_words", out_log.size(), 4);
    chk_entry("t5_w0", 0, 8'h80, 64'hE1);
    chk_entry("t5_w1", 1, 8'h00, 64'hE2);
    chk_entry("t5_w2", 2, 8'h00, 64'hE3);
    chk_entry("t5_w3", 3, 8'h43, 64'hE4);

    // randomized traffic with random gaps and read requests
    gen_stream(150);
    cyc = 0;
    while ((src_q.size() > 0 || fifo_q.size() > 0) && cyc < 20000) begin
      if (src_q.size() > 0 && $urandom_range(0, 3) != 0) push(src_q.pop_front());
      ren_u = ($urandom_range(0, 3) != 0);
      step();
      cyc++;
    end
    chk("rand_drained", fifo_q.size(), 0);
    ren_u = 1'b0;
    repeat (2) step();

    // reset pulsed mid-frame
    sp0 = dut_spops;
    push(mkw(8'h80, 64'h51)); push(mkw(8'h00, 64'h52)); push(mkw(8'h00, 64'h53));
    push(mkw(8'h00, 64'h54)); push(mkw(8'h41, 64'h55));
    ren_u = 1'b1;
    repeat (2) step();
    ren_u = 1'b0;
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    repeat (6) step();
    chk("rst_mid_drop_cnt", rx_drop_cnt, 16'd3);
    chk("rst_mid_spop", dut_spops - sp0, 1);

    // sustained garbage drives the drop counter into saturation
    cyc = 0;
    while (m_drops < 65540 && cyc < 70000) begin
      push({{1'b0, 1'b0, 1'($urandom), 2'b00, 3'($urandom)}, $urandom(), $urandom()});
      step();
      cyc++;
    end
    repeat (3) step();
    chk("sat_drop_cnt", rx_drop_cnt, 16'hFFFF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
